// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider family: FSM encoding and a width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Ceiling log2 with a floor of 1, so it is always usable as a counter width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] partial_rem,
  input  logic                 din,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] new_rem,
  output logic                 q_bit
);

  localparam int unsigned SW = DATAWIDTH + 1;

  logic [SW-1:0] shifted;

  // The shifted remainder needs DATAWIDTH+1 bits; the kept remainder is always below the
  // divisor, so it fits back into DATAWIDTH bits.
  always_comb begin
    shifted = {partial_rem, din};
    q_bit   = (shifted >= {1'b0, divisor});
    new_rem = q_bit ? DATAWIDTH'(shifted - {1'b0, divisor}) : shifted[DATAWIDTH-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider with a single-pulse start/done handshake.
// Optional build macro: SEQ_DIV_SIGNED_EN selects two's complement operands.
module seq_div
  import div_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 div_by_zero
);

  localparam int unsigned CW = clog2(DATAWIDTH);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;   // dividend in, quotient bits shift in from the LSB
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH-1:0] prem_q, prem_d;
  logic [DATAWIDTH-1:0] a_q, a_d;       // raw dividend, returned as remainder on divide-by-zero
  logic                 bz_q, bz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 accept;

  logic [DATAWIDTH-1:0] step_rem;
  logic                 step_q;
  logic [DATAWIDTH-1:0] a_mag, b_mag;
  logic [DATAWIDTH-1:0] q_res, r_res;

  div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .partial_rem (prem_q),
    .din         (dvd_q[DATAWIDTH-1]),
    .divisor     (dvs_q),
    .new_rem     (step_rem),
    .q_bit       (step_q)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  function automatic logic [DATAWIDTH-1:0] negate(input logic [DATAWIDTH-1:0] x);
    return '0 - x;
  endfunction

  // Core divides magnitudes; signs are fixed up as the result is registered.
  always_comb begin
    a_mag  = a[DATAWIDTH-1] ? negate(a) : a;
    b_mag  = b[DATAWIDTH-1] ? negate(b) : b;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    if (accept) begin
      qneg_d = a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
      rneg_d = a[DATAWIDTH-1];
    end
    q_res = qneg_q ? negate(dvd_q) : dvd_q;
    r_res = rneg_q ? negate(prem_q) : prem_q;
  end

  // Sign flags of the operation in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  // Unsigned: operands and results pass straight through.
  always_comb begin
    a_mag = a;
    b_mag = b;
    q_res = dvd_q;
    r_res = prem_q;
  end
`endif

  // Next-state, datapath and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    a_d     = a_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = start;
      end
      CALC: begin
        prem_d = step_rem;
        dvd_d  = {dvd_q[DATAWIDTH-2:0], step_q};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        quot_d  = bz_q ? '1 : q_res;
        rem_d   = bz_q ? a_q : r_res;
        dbz_d   = bz_q;
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase

    // A new operation may start from IDLE or straight out of DONE.
    if (accept) begin
      a_d     = a;
      dvd_d   = a_mag;
      dvs_d   = b_mag;
      prem_d  = '0;
      cnt_d   = CW'(DATAWIDTH - 1);
      bz_d    = (b == '0);
      state_d = (b == '0) ? DONE : CALC;
    end

    busy_d = (state_d == CALC);
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      a_q     <= '0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      a_q     <= a_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule
